// File: rtl/pll_lock_sequencer.sv
// Supervises the TMDS PLL from the 27 MHz crystal domain: pulses the PLL reset, qualifies lock,
// retries on timeout and holds sys_rst until lock is stable. Optional macro: LOCK_GLITCH_FILTER_EN.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES = 270000,
    parameter int unsigned STABLE_CYCLES  = 4096,
    parameter int unsigned CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RESET_PLL = 2'd0;
    localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ST_STABLE    = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
`ifdef LOCK_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(3);
`endif

    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q, lock_s_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic [7:0]       relock_cnt_q, relock_cnt_d;
    logic             lock_lost;

    // Two-flop synchronizer; nothing else looks at the raw lock pin.
    always_comb begin
        lock_meta_d = lock;
        lock_s_d    = lock_meta_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        relock_cnt_d = relock_cnt_q;
        lock_lost    = 1'b0;

        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == PLL_RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock is tested before the timeout so a late lock still wins the terminal cycle.
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
                // In RUN the counter tracks consecutive low cycles of the synchronized lock.
                if (lock_s_q) begin
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == LOSS_LAST) begin
                    lock_lost = 1'b1;
                end
`else
                cnt_d = CNT_ZERO;
                if (!lock_s_q) begin
                    lock_lost = 1'b1;
                end
`endif
                if (lock_lost) begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = CNT_ZERO;
                    if (relock_cnt_q != 8'hFF) begin
                        relock_cnt_d = relock_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state register.
    always_comb begin
        pll_rst_d = (state_d == ST_RESET_PLL);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= ST_RESET_PLL;
            cnt_q        <= CNT_ZERO;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            relock_cnt_q <= 8'd0;
        end else begin
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign relock_cnt = relock_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short cycle parameters (4/32/8).
// Inputs are driven and outputs sampled at the falling edge, away from the active edge.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(4),
        .TIMEOUT_CYCLES(32),
        .STABLE_CYCLES (8),
        .CNT_W         (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock      (lock),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .relock_cnt(relock_cnt),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst_v, input logic lock_v);
        rst  = rst_v;
        lock = lock_v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitForState(input logic [1:0] target, input int budget, input string tag);
        int n = 0;
        while (state !== target && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, {30'd0, state}, {30'd0, target});
    endtask

    initial begin
        // Reset and first lock acquisition
        applyStimulus(1'b1, 1'b0);
        tick(2);
        checkOutput("rst_state", {30'd0, state}, 0);
        checkOutput("rst_pll_rst", {31'd0, pll_rst}, 1);
        checkOutput("rst_sys_rst", {31'd0, sys_rst}, 1);
        checkOutput("rst_ready", {31'd0, ready}, 0);
        checkOutput("rst_relock", {24'd0, relock_cnt}, 0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("boot_pll_rst_hi[%0d]", i), {31'd0, pll_rst}, 1);
            tick(1);
        end
        checkOutput("boot_pll_rst_lo", {31'd0, pll_rst}, 0);
        checkOutput("boot_wait_lock", {30'd0, state}, 1);
        tick(6);
        applyStimulus(1'b0, 1'b1);
        tick(2);
        checkOutput("lock_sync_state", {30'd0, state}, 1);
        tick(1);
        checkOutput("lock_stable_state", {30'd0, state}, 2);
        tick(7);
        checkOutput("lock_ready_early", {31'd0, ready}, 0);
        tick(1);
        checkOutput("lock_ready", {31'd0, ready}, 1);
        checkOutput("lock_sys_rst", {31'd0, sys_rst}, 0);
        checkOutput("lock_run_state", {30'd0, state}, 3);
        checkOutput("lock_relock", {24'd0, relock_cnt}, 0);

        // Lock loss in RUN
`ifdef LOCK_GLITCH_FILTER_EN
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(6);
        checkOutput("glitch_state", {30'd0, state}, 3);
        checkOutput("glitch_relock", {24'd0, relock_cnt}, 0);
        checkOutput("glitch_sys_rst", {31'd0, sys_rst}, 0);
        applyStimulus(1'b0, 1'b0);
        tick(5);
        checkOutput("loss5_pre_relock", {24'd0, relock_cnt}, 0);
        checkOutput("loss5_pre_state", {30'd0, state}, 3);
        applyStimulus(1'b0, 1'b1);
        tick(1);
        checkOutput("loss5_relock", {24'd0, relock_cnt}, 1);
        checkOutput("loss5_state", {30'd0, state}, 0);
        checkOutput("loss5_sys_rst", {31'd0, sys_rst}, 1);
        waitForState(2'd3, 40, "loss5_rerun");
`else
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(1);
        checkOutput("loss_sys_rst_e2", {31'd0, sys_rst}, 0);
        checkOutput("loss_state_e2", {30'd0, state}, 3);
        tick(1);
        checkOutput("loss_state_e3", {30'd0, state}, 0);
        checkOutput("loss_sys_rst_e3", {31'd0, sys_rst}, 1);
        checkOutput("loss_pll_rst_e3", {31'd0, pll_rst}, 1);
        checkOutput("loss_ready_e3", {31'd0, ready}, 0);
        checkOutput("loss_relock_e3", {24'd0, relock_cnt}, 1);
        tick(3);
        checkOutput("loss_pll_rst_e6", {31'd0, pll_rst}, 1);
        tick(1);
        checkOutput("loss_pll_rst_e7", {31'd0, pll_rst}, 0);
        checkOutput("loss_state_e7", {30'd0, state}, 1);
        tick(1);
        checkOutput("loss_state_e8", {30'd0, state}, 2);
        tick(7);
        checkOutput("loss_ready_e15", {31'd0, ready}, 0);
        tick(1);
        checkOutput("loss_ready_e16", {31'd0, ready}, 1);
`endif

        // Saturation of the relock counter
        for (int n = 2; n <= 256; n++) begin
            applyStimulus(1'b0, 1'b0);
            tick(5);
            applyStimulus(1'b0, 1'b1);
            waitForState(2'd0, 10, "sat_leave_run");
            waitForState(2'd3, 40, "sat_rerun");
            if (n == 2 || n == 255 || n == 256) begin
                checkOutput($sformatf("sat_relock[%0d]", n), {24'd0, relock_cnt}, (n > 255) ? 255 : n);
            end
        end

        // Reset while in RUN
        applyStimulus(1'b1, 1'b1);
        tick(1);
        checkOutput("rstrun_state", {30'd0, state}, 0);
        checkOutput("rstrun_pll_rst", {31'd0, pll_rst}, 1);
        checkOutput("rstrun_sys_rst", {31'd0, sys_rst}, 1);
        checkOutput("rstrun_ready", {31'd0, ready}, 0);
        checkOutput("rstrun_relock", {24'd0, relock_cnt}, 0);
        applyStimulus(1'b0, 1'b1);

        // Lock glitch in STABLE, landing on the terminal count
        tick(10);
        checkOutput("stab_pre_state", {30'd0, state}, 2);
        applyStimulus(1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b1);
        tick(1);
        checkOutput("stab_e12_state", {30'd0, state}, 2);
        tick(1);
        checkOutput("stab_back_wait", {30'd0, state}, 1);
        tick(1);
        checkOutput("stab_reenter", {30'd0, state}, 2);
        tick(7);
        checkOutput("stab_ready_early", {31'd0, ready}, 0);
        checkOutput("stab_state_early", {30'd0, state}, 2);
        tick(1);
        checkOutput("stab_ready", {31'd0, ready}, 1);
        checkOutput("stab_run", {30'd0, state}, 3);

        // No lock: periodic PLL retries
        applyStimulus(1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 76; i++) begin
            checkOutput($sformatf("retry_pll_rst[%0d]", i), {31'd0, pll_rst}, ((i % 36) < 4) ? 1 : 0);
            checkOutput($sformatf("retry_state[%0d]", i), {30'd0, state}, ((i % 36) < 4) ? 0 : 1);
            checkOutput($sformatf("retry_ready[%0d]", i), {31'd0, ready}, 0);
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
